// File: rtl/axi_lite_terminator_if.sv
// AXI4-Lite bus bundle for the terminator: master drives requests, slave drives
// ready/response signals.
interface axi_lite_terminator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_terminator.sv
// AXI4-Lite sink that answers every access with a fixed error response and counts
// completed transactions. Define AXIL_TERM_CAPTURE_EN to add first-error address capture.
module axi_lite_terminator #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [1:0]            RESP       = 2'b11,
  parameter logic [DATA_WIDTH-1:0] RDATA_FILL = {DATA_WIDTH/32{32'hDEADBEEF}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_lite_terminator_if.slave s_axil,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] rd_count
`ifdef AXIL_TERM_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_write,
  output logic                  err_valid,
  input  logic                  err_clear
`endif
);

  typedef enum logic {W_ADDR_DATA, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic     aw_got, w_got;
  logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic     aw_done, w_done;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign aw_hs   = s_axil.awvalid && s_axil.awready;
  assign w_hs    = s_axil.wvalid && s_axil.wready;
  assign b_hs    = s_axil.bvalid && s_axil.bready;
  assign ar_hs   = s_axil.arvalid && s_axil.arready;
  assign r_hs    = s_axil.rvalid && s_axil.rready;
  assign aw_done = aw_got || aw_hs;
  assign w_done  = w_got || w_hs;

  // Payload never influences the response.
  logic unused_payload;
  assign unused_payload = ^{s_axil.awaddr, s_axil.araddr, s_axil.wdata, s_axil.wstrb};

  // Write path: readies are registered so they stay low until the first edge out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state        <= W_ADDR_DATA;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= 2'b00;
    end else begin
      case (w_state)
        W_ADDR_DATA: begin
          if (aw_done && w_done) begin
            w_state        <= W_RESP;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            s_axil.bvalid  <= 1'b1;
            s_axil.bresp   <= RESP;
          end else begin
            aw_got         <= aw_done;
            w_got          <= w_done;
            s_axil.awready <= !aw_done;
            s_axil.wready  <= !w_done;
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            w_state        <= W_ADDR_DATA;
            s_axil.bvalid  <= 1'b0;
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
          end
        end
        default: w_state <= W_ADDR_DATA;
      endcase
    end
  end

  // Read path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= R_ADDR;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rresp   <= 2'b00;
      s_axil.rdata   <= '0;
    end else begin
      case (r_state)
        R_ADDR: begin
          if (ar_hs) begin
            r_state        <= R_RESP;
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b1;
            s_axil.rresp   <= RESP;
            s_axil.rdata   <= RDATA_FILL;
          end else begin
            s_axil.arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axil.rready) begin
            r_state        <= R_ADDR;
            s_axil.rvalid  <= 1'b0;
            s_axil.arready <= 1'b1;
          end
        end
        default: r_state <= R_ADDR;
      endcase
    end
  end

  // Completion counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (b_hs) wr_count <= sat_inc(wr_count);
      if (r_hs) rd_count <= sat_inc(rd_count);
    end
  end

`ifdef AXIL_TERM_CAPTURE_EN
  // First-error capture; a write wins a same-cycle tie and clear beats capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_addr     <= '0;
      err_is_write <= 1'b0;
      err_valid    <= 1'b0;
    end else if (err_clear) begin
      err_valid <= 1'b0;
    end else if (!err_valid && (aw_hs || ar_hs)) begin
      err_valid    <= 1'b1;
      err_is_write <= aw_hs;
      err_addr     <= aw_hs ? s_axil.awaddr : s_axil.araddr;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_terminator.sv
// Directed bench for axi_lite_terminator: cycle table for both paths plus hand
// sequences for counter saturation, mid-transaction reset and error capture.
module tb_axi_lite_terminator;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_terminator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axi_lite_terminator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  logic [15:0] wr_count, rd_count;
  logic [1:0]  wr_count2, rd_count2;
`ifdef AXIL_TERM_CAPTURE_EN
  logic [31:0] err_addr, err_addr2;
  logic        err_is_write, err_valid, err_is_write2, err_valid2;
  logic        err_clear = 1'b0;
  logic        err_clear2 = 1'b0;
`endif

  axi_lite_terminator #(.CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axil(bus),
    .wr_count(wr_count), .rd_count(rd_count)
`ifdef AXIL_TERM_CAPTURE_EN
    , .err_addr(err_addr), .err_is_write(err_is_write),
    .err_valid(err_valid), .err_clear(err_clear)
`endif
  );

  axi_lite_terminator #(.CNT_WIDTH(2)) dut_small (
    .aclk(aclk), .aresetn(aresetn), .s_axil(bus2),
    .wr_count(wr_count2), .rd_count(rd_count2)
`ifdef AXIL_TERM_CAPTURE_EN
    , .err_addr(err_addr2), .err_is_write(err_is_write2),
    .err_valid(err_valid2), .err_clear(err_clear2)
`endif
  );

  int total = 0;
  int bad = 0;

  // inp = {awvalid, wvalid, bready, arvalid, rready}
  // exp = {awready, wready, bvalid, arready, rvalid}
  typedef struct {
    logic [4:0] inp;
    logic [4:0] exp;
    int         wc;
    int         rc;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v);
    bus.awvalid = v[4];
    bus.wvalid  = v[3];
    bus.bready  = v[2];
    bus.arvalid = v[1];
    bus.rready  = v[0];
    bus.awaddr  = $urandom;
    bus.araddr  = $urandom;
    bus.wdata   = $urandom;
    bus.wstrb   = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{5'b00000, 5'b11010, 0, 0};
    tbl[1]  = '{5'b11100, 5'b00110, 0, 0};
    tbl[2]  = '{5'b00100, 5'b11010, 1, 0};
    tbl[3]  = '{5'b01000, 5'b10010, 1, 0};
    tbl[4]  = '{5'b00000, 5'b10010, 1, 0};
    tbl[5]  = '{5'b00000, 5'b10010, 1, 0};
    tbl[6]  = '{5'b10000, 5'b00110, 1, 0};
    tbl[7]  = '{5'b00000, 5'b00110, 1, 0};
    tbl[8]  = '{5'b00000, 5'b00110, 1, 0};
    tbl[9]  = '{5'b00000, 5'b00110, 1, 0};
    tbl[10] = '{5'b00000, 5'b00110, 1, 0};
    tbl[11] = '{5'b00000, 5'b00110, 1, 0};
    tbl[12] = '{5'b00100, 5'b11010, 2, 0};
    tbl[13] = '{5'b11111, 5'b00101, 2, 0};
    tbl[14] = '{5'b00101, 5'b11010, 3, 1};
    tbl[15] = '{5'b10000, 5'b01010, 3, 1};
    tbl[16] = '{5'b01110, 5'b00101, 3, 1};
    tbl[17] = '{5'b00100, 5'b11001, 4, 1};
    tbl[18] = '{5'b00001, 5'b11010, 4, 2};

    drive(5'b00000);
    bus2.awvalid = 1'b0; bus2.wvalid = 1'b0; bus2.bready = 1'b0;
    bus2.arvalid = 1'b0; bus2.rready = 1'b0;
    bus2.awaddr = '0; bus2.araddr = '0; bus2.wdata = '0; bus2.wstrb = '0;

    // Reset values, with an edge passing while reset is held
    #12;
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
`ifdef AXIL_TERM_CAPTURE_EN
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_is_write", err_is_write, 0);
`endif
    step();
    aresetn = 1'b1;
    #2;
    chk("ready_before_edge_aw", bus.awready, 0);
    chk("ready_before_edge_ar", bus.arready, 0);
    #1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].inp);
      step();
      chk($sformatf("v%0d_awready", i), bus.awready, tbl[i].exp[4]);
      chk($sformatf("v%0d_wready", i), bus.wready, tbl[i].exp[3]);
      chk($sformatf("v%0d_bvalid", i), bus.bvalid, tbl[i].exp[2]);
      chk($sformatf("v%0d_arready", i), bus.arready, tbl[i].exp[1]);
      chk($sformatf("v%0d_rvalid", i), bus.rvalid, tbl[i].exp[0]);
      chk($sformatf("v%0d_wr_count", i), wr_count, tbl[i].wc);
      chk($sformatf("v%0d_rd_count", i), rd_count, tbl[i].rc);
      if (tbl[i].exp[2]) chk($sformatf("v%0d_bresp", i), bus.bresp, 2'b11);
      if (tbl[i].exp[0]) begin
        chk($sformatf("v%0d_rresp", i), bus.rresp, 2'b11);
        chk($sformatf("v%0d_rdata", i), bus.rdata, 32'hDEADBEEF);
      end
    end
    drive(5'b00000);

    // Narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      bus2.araddr = 32'h1000 + 32'(i);
      bus2.arvalid = 1'b1;
      bus2.rready = 1'b0;
      step();
      chk($sformatf("sat%0d_rvalid", i), bus2.rvalid, 1);
      bus2.arvalid = 1'b0;
      bus2.rready = 1'b1;
      step();
      chk($sformatf("sat%0d_rd_count", i), rd_count2, (i < 3) ? i + 1 : 3);
    end
    bus2.rready = 1'b0;

    // Reset while a write response is pending
    drive(5'b11000);
    step();
    chk("pre_rst_bvalid", bus.bvalid, 1);
    drive(5'b00000);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_bvalid", bus.bvalid, 0);
    chk("async_rst_wr_count", wr_count, 0);
    chk("async_rst_rd_count", rd_count, 0);
    chk("async_rst_awready", bus.awready, 0);
    step();
    aresetn = 1'b1;
    step();
    chk("post_rst_awready", bus.awready, 1);
    drive(5'b11100);
    step();
    chk("post_rst_bvalid", bus.bvalid, 1);
    chk("post_rst_bresp", bus.bresp, 2'b11);
    drive(5'b00100);
    step();
    chk("post_rst_wr_count", wr_count, 1);
    chk("post_rst_bvalid_done", bus.bvalid, 0);
    drive(5'b00000);

`ifdef AXIL_TERM_CAPTURE_EN
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("cap_cleared", err_valid, 0);
    drive(5'b11111);
    bus.awaddr = 32'h40;
    bus.araddr = 32'h80;
    step();
    chk("cap_valid", err_valid, 1);
    chk("cap_addr", err_addr, 32'h40);
    chk("cap_is_write", err_is_write, 1);
    drive(5'b00101);
    step();
    drive(5'b00011);
    bus.araddr = 32'h100;
    step();
    drive(5'b00001);
    step();
    chk("cap_hold_addr", err_addr, 32'h40);
    chk("cap_hold_write", err_is_write, 1);
    err_clear = 1'b1;
    step();
    chk("cap_clear", err_valid, 0);
    drive(5'b00010);
    bus.araddr = 32'h200;
    step();
    err_clear = 1'b0;
    chk("cap_clear_wins", err_valid, 0);
    drive(5'b00001);
    step();
    drive(5'b00000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
